// File: rtl/voice_dispatcher.sv
// MIDI voice dispatcher: maps note/sustain messages onto PIPELINE_COUNT synthesis voices
// using lowest-free allocation and LRU stealing, with one-cycle registered note commands.

package MIDI;
    typedef enum logic [2:0] {
        NOTE_OFF         = 3'd0,
        NOTE_ON          = 3'd1,
        POLY_PRESSURE    = 3'd2,
        CONTROL_CHANGE   = 3'd3,
        PROGRAM_CHANGE   = 3'd4,
        CHANNEL_PRESSURE = 3'd5,
        PITCH_BEND       = 3'd6,
        SYSTEM           = 3'd7
    } message_type_t;

    typedef struct packed {
        message_type_t message_type;
        logic [3:0]    channel;
        logic [6:0]    data_byte1;
        logic [6:0]    data_byte2;
    } message_t;

    typedef enum logic {
        STATUS_OFF = 1'b0,
        STATUS_ON  = 1'b1
    } note_status_t;

    typedef struct packed {
        note_status_t status;
        logic [6:0]   note_number;
        logic [6:0]   velocity;
    } note_change_t;
endpackage

// Handshake: a message is consumed on any rising edge where message_ready=1 and its
// channel is enabled; there is no backpressure. Each pipeline_notes_ready bit is a
// one-cycle strobe qualifying the matching pipeline_notes entry on that same cycle.
module voice_dispatcher #(
    parameter int          PIPELINE_COUNT = 4,
    parameter logic [15:0] CHANNEL_MASK   = 16'hFFFF
) (
    input  logic                                   clock_50_000_000,
    input  logic                                   reset_l,
    input  MIDI::message_t                         message,
    input  logic                                   message_ready,
    output MIDI::note_change_t [PIPELINE_COUNT-1:0] pipeline_notes,
    output logic [PIPELINE_COUNT-1:0]              pipeline_notes_ready,
    output logic [PIPELINE_COUNT-1:0]              voices_busy,
    output logic                                   sustain_active,
    output logic [2*PIPELINE_COUNT-1:0]            voice_state_dbg
);

    localparam int IDX_W = (PIPELINE_COUNT > 1) ? $clog2(PIPELINE_COUNT) : 1;

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        HELD      = 2'd1,
        SUSTAINED = 2'd2
    } voice_state_t;

    voice_state_t     state [PIPELINE_COUNT];
    logic [6:0]       note  [PIPELINE_COUNT];
    logic [IDX_W-1:0] age   [PIPELINE_COUNT];

    logic             accept, is_on, is_off, is_pedal, pedal_down;
    logic             on_hit, off_hit, free_hit;
    logic [IDX_W-1:0] on_idx, off_idx, free_idx, old_idx, target;

    always_comb begin
        accept     = message_ready && CHANNEL_MASK[message.channel];
        is_on      = accept && (message.message_type == MIDI::NOTE_ON) && (message.data_byte2 != 7'd0);
        is_off     = accept && ((message.message_type == MIDI::NOTE_OFF) ||
                                ((message.message_type == MIDI::NOTE_ON) && (message.data_byte2 == 7'd0)));
        is_pedal   = accept && (message.message_type == MIDI::CONTROL_CHANGE) && (message.data_byte1 == 7'd64);
        pedal_down = message.data_byte2[6];
        on_hit     = 1'b0;
        off_hit    = 1'b0;
        free_hit   = 1'b0;
        on_idx     = '0;
        off_idx    = '0;
        free_idx   = '0;
        old_idx    = '0;
        // Ascending scan with first-hit flags gives lowest-index priority everywhere.
        for (int v = 0; v < PIPELINE_COUNT; v++) begin
            if (!on_hit && state[v] != FREE && note[v] == message.data_byte1) begin
                on_hit = 1'b1;
                on_idx = IDX_W'(v);
            end
            if (!off_hit && state[v] == HELD && note[v] == message.data_byte1) begin
                off_hit = 1'b1;
                off_idx = IDX_W'(v);
            end
            if (!free_hit && state[v] == FREE) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(v);
            end
            if (age[v] > age[old_idx]) begin
                old_idx = IDX_W'(v);
            end
        end
        target = on_hit ? on_idx : (free_hit ? free_idx : old_idx);
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            for (int v = 0; v < PIPELINE_COUNT; v++) begin
                state[v] <= FREE;
                note[v]  <= '0;
                age[v]   <= IDX_W'(v);
            end
            pipeline_notes       <= '0;
            pipeline_notes_ready <= '0;
            sustain_active       <= 1'b0;
        end else begin
            pipeline_notes_ready <= '0;
            if (is_on) begin
                state[target]                <= HELD;
                note[target]                 <= message.data_byte1;
                pipeline_notes[target]       <= MIDI::note_change_t'{MIDI::STATUS_ON, message.data_byte1, message.data_byte2};
                pipeline_notes_ready[target] <= 1'b1;
                for (int v = 0; v < PIPELINE_COUNT; v++) begin
                    if (IDX_W'(v) == target) begin
                        age[v] <= '0;
                    end else if (age[v] < age[target]) begin
                        age[v] <= age[v] + 1'b1;
                    end
                end
            end else if (is_off && off_hit) begin
                if (sustain_active) begin
                    state[off_idx] <= SUSTAINED;
                end else begin
                    state[off_idx]                <= FREE;
                    pipeline_notes[off_idx]       <= MIDI::note_change_t'{MIDI::STATUS_OFF, note[off_idx], message.data_byte2};
                    pipeline_notes_ready[off_idx] <= 1'b1;
                end
            end else if (is_pedal) begin
                if (pedal_down) begin
                    sustain_active <= 1'b1;
                end else if (sustain_active) begin
                    // Pedal release silences every sustained voice on the same edge.
                    sustain_active <= 1'b0;
                    for (int v = 0; v < PIPELINE_COUNT; v++) begin
                        if (state[v] == SUSTAINED) begin
                            state[v]                <= FREE;
                            pipeline_notes[v]       <= MIDI::note_change_t'{MIDI::STATUS_OFF, note[v], 7'd0};
                            pipeline_notes_ready[v] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        voices_busy     = '0;
        voice_state_dbg = '0;
        for (int v = 0; v < PIPELINE_COUNT; v++) begin
            voices_busy[v]            = (state[v] != FREE);
            voice_state_dbg[2*v +: 2] = state[v];
        end
    end

endmodule

// File: doc/voice_dispatcher.md
VOICE_DISPATCHER -- requirements
Module: voice_dispatcher

Interface
REQ-001 SHALL have parameter PIPELINE_COUNT, default 4, number of synthesis pipelines (voices), legal range 1..16.
REQ-002 SHALL have parameter CHANNEL_MASK, default 16'hFFFF, bit n set = MIDI channel n accepted.
REQ-003 SHALL have port clock_50_000_000  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset_l  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port message  input  MIDI::message_t  parsed message (message_type, channel[3:0], data_byte1[6:0], data_byte2[6:0]).
REQ-006 SHALL have port message_ready  input  1  message valid this cycle; at most one message per cycle.
REQ-007 SHALL have port pipeline_notes  output  note_change_t[PIPELINE_COUNT]  per-voice note command (status, note_number, velocity).
REQ-008 SHALL have port pipeline_notes_ready  output  [PIPELINE_COUNT]  per-voice single-cycle strobe qualifying pipeline_notes.
REQ-009 SHALL have port voices_busy  output  [PIPELINE_COUNT]  voice allocated (key held or sustained).
REQ-010 SHALL have port sustain_active  output  1  sustain pedal state.

Function
REQ-011 A message SHALL be accepted only when message_ready=1 and CHANNEL_MASK[message.channel]=1; all others ignored, no state change.
REQ-012 NOTE_ON with data_byte2=0 SHALL be handled exactly as NOTE_OFF.
REQ-013 Per-voice state SHALL be: FREE, HELD (key down), SUSTAINED (key up, pedal down); plus stored note_number and an LRU age rank.
REQ-014 NOTE_ON, note already in a HELD/SUSTAINED voice: that voice SHALL be retriggered (goes HELD, becomes youngest).
REQ-015 NOTE_ON, otherwise: lowest-index FREE voice SHALL be allocated; if none FREE, oldest voice (highest age rank, lowest index on tie) SHALL be stolen.
REQ-016 Allocated/retriggered/stolen voice SHALL emit {ON, data_byte1, data_byte2} with its ready strobe; no separate OFF on steal.
REQ-017 NOTE_OFF matching a HELD voice: pedal up -> emit {OFF, note, data_byte2}, voice FREE; pedal down -> voice SUSTAINED, no output.
REQ-018 NOTE_OFF matching no HELD voice SHALL be ignored.
REQ-019 CONTROL_CHANGE with data_byte1=64: data_byte2>=64 sets sustain_active; data_byte2<64 clears it and SHALL emit {OFF, stored note, velocity 0} on every SUSTAINED voice simultaneously, freeing them.
REQ-020 Pedal-on while already on, or pedal-off while off, SHALL produce no output.
REQ-021 Age ranks SHALL form a permutation of 0..PIPELINE_COUNT-1; touched voice -> 0, voices younger than its previous rank increment by 1, others unchanged.
REQ-022 Latency SHALL be exactly 1 cycle: response registered on the edge after the accepting cycle.
REQ-023 pipeline_notes_ready bits SHALL be high for exactly one cycle per command; pipeline_notes[v] holds its last value otherwise.
REQ-024 Back-to-back accepted messages on consecutive cycles SHALL each be processed fully, in order, with no loss.
REQ-025 voices_busy and sustain_active SHALL update on the same edge as the corresponding command.
REQ-026 Other message types SHALL be ignored.

Reset
REQ-027 While reset_l=0: all voices FREE, age ranks = voice index, sustain_active=0, pipeline_notes=0, pipeline_notes_ready=0, voices_busy=0.
REQ-028 Reset asserted mid-operation SHALL discard all held/sustained notes with no OFF commands emitted.

Verification
REQ-029 NOTE_ON ch0 note 60 vel 100 after reset -> next cycle pipeline_notes[0]={ON,60,100}, ready=4'b0001, voices_busy=4'b0001.
REQ-030 Five NOTE_ONs notes 60..64 back-to-back (PIPELINE_COUNT=4) -> voices 0..3 get 60..63, note 64 steals voice 0, ready=4'b0001 on the fifth response.
REQ-031 NOTE_ON 60, CC64=127, NOTE_OFF 60 -> no output on OFF, voice 0 SUSTAINED; CC64=0 -> {OFF,60,0} on voice 0, voices_busy=0.
REQ-032 NOTE_ON 60 vel 0 while note 60 HELD on voice 2 -> {OFF,60,0} on voice 2, voice freed.
REQ-033 CHANNEL_MASK=16'h0001, NOTE_ON on channel 3 -> no strobe, voices_busy unchanged.
REQ-034 Three voices HELD, reset_l pulsed low mid-stream -> all outputs 0 asynchronously, no OFF strobes after release.
